// File: rtl/bright_contrast_adj.sv
// Brightness/contrast pixel stage: saturating step-controlled offset/gain and a 3-stage datapath.
// Optional macro BC_FRAME_SYNC_EN: active levels load from pending only at an in_vs rising edge.
module bright_contrast_adj #(
  parameter int unsigned STEP_B = 16,
  parameter int unsigned STEP_C = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       binc,
  input  logic       bdec,
  input  logic       cinc,
  input  logic       cdec,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_de,
  input  logic       in_hs,
  input  logic       in_vs,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_de,
  output logic       out_hs,
  output logic       out_vs,
  output logic [7:0] bright_lvl,
  output logic [4:0] contrast_lvl
);
  localparam int unsigned NCH = 3;
  localparam logic signed [9:0] STEP_B_S = 10'(STEP_B);
  localparam logic signed [6:0] STEP_C_S = 7'(STEP_C);
  localparam logic signed [7:0] OFF_MAX  = 8'sh7F;
  localparam logic signed [7:0] OFF_MIN  = 8'sh80;
  localparam logic [4:0]        GAIN_ONE = 5'd16;

  logic signed [7:0] pend_off, cur_off, off_nxt;
  logic [4:0]        pend_gain, cur_gain, gain_nxt;
  logic signed [9:0] off_sum;
  logic signed [6:0] gain_sum;
  logic              load;

  // Saturating next value for the pending offset and gain
  always_comb begin
    off_sum  = 10'(pend_off);
    gain_sum = 7'({2'b00, pend_gain});
    if (binc && !bdec)      off_sum = off_sum + STEP_B_S;
    else if (bdec && !binc) off_sum = off_sum - STEP_B_S;
    if (cinc && !cdec)      gain_sum = gain_sum + STEP_C_S;
    else if (cdec && !cinc) gain_sum = gain_sum - STEP_C_S;

    if (off_sum > 10'(OFF_MAX))      off_nxt = OFF_MAX;
    else if (off_sum < 10'(OFF_MIN)) off_nxt = OFF_MIN;
    else                             off_nxt = 8'(off_sum);

    if (gain_sum < 7'sd0)       gain_nxt = 5'd0;
    else if (gain_sum > 7'sd31) gain_nxt = 5'd31;
    else                        gain_nxt = 5'(gain_sum);
  end

`ifdef BC_FRAME_SYNC_EN
  logic vs_prev;

  always_ff @(posedge clk) begin
    if (!rst) vs_prev <= 1'b0;
    else      vs_prev <= in_vs;
  end

  assign load = in_vs & ~vs_prev;
`else
  assign load = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_off  <= '0;
      pend_gain <= GAIN_ONE;
      cur_off   <= '0;
      cur_gain  <= GAIN_ONE;
    end else begin
      if (en) begin
        pend_off  <= off_nxt;
        pend_gain <= gain_nxt;
      end
      if (load) begin
        cur_off  <= pend_off;
        cur_gain <= pend_gain;
      end
    end
  end

  assign bright_lvl   = cur_off;
  assign contrast_lvl = cur_gain;

  logic [7:0]         px     [NCH];
  logic signed [8:0]  d      [NCH];
  logic signed [13:0] m      [NCH];
  logic signed [10:0] s      [NCH];
  logic [7:0]         sat    [NCH];
  logic signed [13:0] s1_m   [NCH];
  logic [7:0]         s1_p   [NCH];
  logic signed [10:0] s2_s   [NCH];
  logic [7:0]         s2_p   [NCH];
  logic [7:0]         o_px   [NCH];
  logic [2:0]         s1_sync, s2_sync, o_sync;
  logic               s1_en, s2_en;

  assign px[0] = in_r;
  assign px[1] = in_g;
  assign px[2] = in_b;

  // Per-channel arithmetic feeding each pipeline stage
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      d[i] = signed'({1'b0, px[i]}) - 9'sd128;
      m[i] = 14'(d[i]) * 14'(signed'({1'b0, cur_gain}));
      s[i] = 11'(s1_m[i] >>> 4) + 11'sd128 + 11'(cur_off);
      if (s2_s[i] < 11'sd0)        sat[i] = 8'd0;
      else if (s2_s[i] > 11'sd255) sat[i] = 8'hFF;
      else                         sat[i] = 8'(s2_s[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        s1_m[i] <= '0;
        s1_p[i] <= '0;
        s2_s[i] <= '0;
        s2_p[i] <= '0;
        o_px[i] <= '0;
      end
      s1_sync <= '0;
      s2_sync <= '0;
      o_sync  <= '0;
      s1_en   <= 1'b0;
      s2_en   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s1_m[i] <= m[i];
        s1_p[i] <= px[i];
        s2_s[i] <= s[i];
        s2_p[i] <= s1_p[i];
        o_px[i] <= s2_en ? sat[i] : s2_p[i];
      end
      s1_sync <= {in_de, in_hs, in_vs};
      s2_sync <= s1_sync;
      o_sync  <= s2_sync;
      s1_en   <= en;
      s2_en   <= s1_en;
    end
  end

  assign out_r  = o_px[0];
  assign out_g  = o_px[1];
  assign out_b  = o_px[2];
  assign out_de = o_sync[2];
  assign out_hs = o_sync[1];
  assign out_vs = o_sync[0];
endmodule

// File: doc/bright_contrast_adj.md
# bright_contrast_adj

Pixel-stream stage directly downstream of the control block. Consumes the single-cycle brightness/contrast step pulses and the brightness enable bit, keeps saturating brightness-offset and contrast-gain registers, and applies `out = clamp((p − 128)·gain/16 + 128 + offset)` per colour channel. The three-stage pipeline carries the video sync/valid signals alongside the pixels, so downstream effect stages see an aligned stream.

## Interface
- `STEP_B`, 16: brightness offset change per `binc`/`bdec` pulse, in code units.
- `STEP_C`, 1: contrast gain change per `cinc`/`cdec` pulse, in 1/16 units.
- `clk` in 1: pixel clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `en` in 1: brightness/contrast enable (control `en[0]`). 0 = bypass.
- `binc`, `bdec`, `cinc`, `cdec` in 1 each: one-cycle step pulses.
- `in_r`, `in_g`, `in_b` in 8 each: input pixel.
- `in_de`, `in_hs`, `in_vs` in 1 each: data valid, hsync, vsync.
- `out_r`, `out_g`, `out_b` out 8 each: adjusted pixel.
- `out_de`, `out_hs`, `out_vs` out 1 each: sync signals delayed to match the pixel.
- `bright_lvl` out 8: active offset, two's complement, −128..+127.
- `contrast_lvl` out 5: active gain, 0..31, where 16 = 1.0.

## Operation
- Pending registers `pend_off` (signed 8-bit) and `pend_gain` (5-bit) update on the cycle after a pulse:
  - Each pulse is honoured only while `en`=1.
  - `binc` adds `STEP_B`; `bdec` subtracts it. The result clamps to −128..+127.
  - `cinc`/`cdec` add or subtract `STEP_C`. The result clamps to 0..31.
  - `binc`&`bdec` together: offset unchanged. `cinc`&`cdec` together: gain unchanged. A brightness pulse and a contrast pulse together are both applied.
- Active registers `cur_off` and `cur_gain` feed the datapath and the `*_lvl` outputs. They load from the pending registers as defined under Configuration.
- Datapath, per channel:
  - S1: `d = p − 128` (signed 9-bit); `m = d · cur_gain` (signed 14-bit).
  - S2: `s = (m >>> 4) + 128 + cur_off` (signed 11-bit; arithmetic shift rounds toward −∞).
  - S3: clamp `s` to 0..255 and register to the outputs.
- Bypass (`en`=0): the pipeline still runs at full latency, with S3 selecting the input pixel delayed by 3. The pending and active levels are held.
- `en` is sampled at S1 and travels with its pixel, so mode switches never mix within one pixel.
- Reset (`rst`=0 on a clock edge):
  - Offsets and levels: `pend_off` = `cur_off` = 0; `pend_gain` = `cur_gain` = 16.
  - Pixel and sync outputs: all pipeline registers and outputs go to 0, including `out_de`, `out_hs` and `out_vs`.
  - Reset mid-frame discards in-flight pixels; there is no partial flush.

## Timing
- Latency is 3 clocks, input to output, for the pixel, `de`, `hs` and `vs`, in both enabled and bypass modes.
- Throughput is one pixel per clock; there is no backpressure.
- Pulse to pending register: 1 clock.
- Pending to active register: 1 clock without the macro; the next `in_vs` rising edge with it.
- `*_lvl` outputs change on the same edge as the active registers.
- `en` falling with a pulse on the same cycle: the pulse is ignored.

## Configuration
- `BC_FRAME_SYNC_EN` defined: active registers load from pending only on the cycle after an `in_vs` 0→1 transition. Any number of pulses within a frame accumulate in pending, with saturation, and take effect together at the frame boundary, giving tear-free updates.
- `BC_FRAME_SYNC_EN` undefined: active registers load from pending every clock, so a change takes effect 2 clocks after the pulse, mid-frame.

## Test plan
- Reset then release, `en`=1: `bright_lvl`=0 and `contrast_lvl`=16. Input pixels 0, 77, 200, 255 appear unchanged 3 clocks later, with `de`/`hs`/`vs` aligned.
- `en`=0 with random pulses: `out_*` equals the input delayed by 3, and the levels stay 0/16.
- 10 `binc` pulses (with `STEP_B`=16): `bright_lvl` = 127, not 160. Input 200 then gives 255; input 50 gives 177. Then 20 `bdec` pulses: `bright_lvl` = −128, and input 100 gives 0.
- Offset 0, 16 `cinc` pulses: gain clamps at 31. Input 200 gives 128 + floor(72·31/16) = 267 → 255; input 100 gives 128 + floor(−28·31/16) = 73.
- Simultaneous `binc`+`bdec` and simultaneous `cinc`+`cdec`: levels unchanged. `binc`+`cinc` together: both step.
- With `BC_FRAME_SYNC_EN`: three `binc` pulses mid-frame leave `bright_lvl` at 0 until the cycle after the `in_vs` rise, then it reads 48. Without the macro, it reads 16/32/48, each 2 clocks after its pulse.
